// File: rtl/wb_interconnect_n_if.sv
// Bus bundle between one pipelined Wishbone master, the interconnect and N slaves.
// The interconnect uses the slave modport; the master modport is the mirror view for the environment.
interface wb_interconnect_n_if #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int N_SLAVES = 4
);
  // Master side
  logic                   i_wb_cyc;
  logic                   i_wb_stb;
  logic                   i_wb_we;
  logic [AW-1:0]          i_wb_addr;
  logic [DW-1:0]          i_wb_data;
  logic [DW/8-1:0]        i_wb_sel;
  logic                   o_wb_stall;
  logic                   o_wb_ack;
  logic                   o_wb_err;
  logic [DW-1:0]          o_wb_data;

  // Slave side; slave k read data sits at [k*DW +: DW]
  logic [N_SLAVES-1:0]    o_s_cyc;
  logic [N_SLAVES-1:0]    o_s_stb;
  logic                   o_s_we;
  logic [AW-1:0]          o_s_addr;
  logic [DW-1:0]          o_s_data;
  logic [DW/8-1:0]        o_s_sel;
  logic [N_SLAVES-1:0]    i_s_stall;
  logic [N_SLAVES-1:0]    i_s_ack;
  logic [N_SLAVES-1:0]    i_s_err;
  logic [N_SLAVES*DW-1:0] i_s_data;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
    output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
    input  i_s_stall, i_s_ack, i_s_err, i_s_data
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
    input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
    output i_s_stall, i_s_ack, i_s_err, i_s_data
  );
endinterface

// File: rtl/wb_interconnect_n.sv
// Single-master, N-slave pipelined Wishbone decoder/router with outstanding-request
// tracking, unmapped-address error and a watchdog that aborts a hung cycle.
module wb_interconnect_n #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_W    = 2,
  parameter int MAX_OUT  = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  wb_interconnect_n_if.slave   bus
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, BADADDR, ABORT} state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    idx, lock;
  logic                mapped;
  logic [OW-1:0]       cnt, cnt_nxt;
  logic [WW-1:0]       wd, wd_nxt;
  logic [N_SLAVES-1:0] s_cyc, s_stb;
  logic                stall, accept, bad, resp_ack, resp_err, timeout;
  logic                ack_q, err_q;
  logic [DW-1:0]       data_q;

  assign idx    = bus.i_wb_addr[AW-1 -: SEL_W];
  assign mapped = (int'(idx) < N_SLAVES);

  // NOTE: every always_comb output gets a default before the case so no path infers a latch.
  always_comb begin
    s_cyc     = '0;
    s_stb     = '0;
    stall     = 1'b0;
    accept    = 1'b0;
    bad       = 1'b0;
    resp_ack  = 1'b0;
    resp_err  = 1'b0;
    timeout   = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    wd_nxt    = '0;

    case (state)
      IDLE: begin
        if (bus.i_wb_cyc && bus.i_wb_stb) begin
          if (mapped) begin
            s_cyc[idx] = 1'b1;
            s_stb[idx] = 1'b1;
            stall      = bus.i_s_stall[idx];
            accept     = !stall;
            if (accept) begin
              state_nxt = BUSY;
              cnt_nxt   = OW'(1);
            end
          end else begin
            bad       = 1'b1;
            state_nxt = BADADDR;
          end
        end
      end

      BUSY: begin
        s_cyc[lock] = 1'b1;
        // Only the locked slave may take new strobes, and only while there is room to track them
        if (idx == lock && cnt < OW'(MAX_OUT)) begin
          s_stb[lock] = bus.i_wb_stb;
          stall       = bus.i_s_stall[lock];
        end else begin
          stall = 1'b1;
        end
        accept   = bus.i_wb_stb && !stall;
        resp_ack = bus.i_s_ack[lock];
        resp_err = bus.i_s_err[lock];
        cnt_nxt  = cnt + OW'(accept) - OW'(resp_ack || resp_err);

        if (accept || resp_ack || resp_err) begin
          wd_nxt = '0;
        end else begin
          wd_nxt  = wd + WW'(1);
          timeout = (wd == WW'(TIMEOUT - 1));
        end

        if (timeout) begin
          cnt_nxt   = '0;
          wd_nxt    = '0;
          state_nxt = ABORT;
        end else if (cnt_nxt == '0) begin
          state_nxt = IDLE;
        end
      end

      BADADDR: begin
        stall     = 1'b1;
        state_nxt = IDLE;
      end

      ABORT: stall = 1'b1;

      default: state_nxt = IDLE;
    endcase

    // Dropping cyc abandons everything in flight, including responses still owed
    if (!bus.i_wb_cyc) begin
      s_cyc     = '0;
      s_stb     = '0;
      stall     = 1'b0;
      accept    = 1'b0;
      bad       = 1'b0;
      resp_ack  = 1'b0;
      resp_err  = 1'b0;
      timeout   = 1'b0;
      state_nxt = IDLE;
      cnt_nxt   = '0;
      wd_nxt    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      lock   <= '0;
      cnt    <= '0;
      wd     <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      wd    <= wd_nxt;
      if (state == IDLE && accept) lock <= idx;
      ack_q <= resp_ack;
      err_q <= resp_err || bad || timeout;
      if (resp_ack) data_q <= bus.i_s_data[int'(lock)*DW +: DW];
    end
  end

  assign bus.o_wb_stall = stall;
  assign bus.o_wb_ack   = ack_q && bus.i_wb_cyc;
  assign bus.o_wb_err   = err_q && bus.i_wb_cyc;
  assign bus.o_wb_data  = data_q;

  assign bus.o_s_cyc  = s_cyc;
  assign bus.o_s_stb  = s_stb;
  assign bus.o_s_we   = bus.i_wb_we && bus.i_wb_cyc;
  assign bus.o_s_addr = bus.i_wb_cyc ? bus.i_wb_addr : '0;
  assign bus.o_s_data = bus.i_wb_cyc ? bus.i_wb_data : '0;
  assign bus.o_s_sel  = bus.i_wb_cyc ? bus.i_wb_sel  : '0;

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Directed bench for wb_interconnect_n with three slaves, MAX_OUT=4 and a 16-cycle watchdog.
module tb_wb_interconnect_n;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int NS = 3;

  logic i_clk = 1'b0;
  logic i_reset;

  int n_checks = 0;
  int n_fail   = 0;

  wb_interconnect_n_if #(.AW(AW), .DW(DW), .N_SLAVES(NS)) bus ();

  wb_interconnect_n #(
    .AW(AW), .DW(DW), .N_SLAVES(NS), .SEL_W(2), .MAX_OUT(4), .TIMEOUT(16)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_sdata(input int k, input logic [31:0] v);
    bus.i_s_data[k*DW +: DW] = v;
  endtask

  int          sent;
  int          acc_cyc[6];
  logic        ack_v;
  logic [15:0] ack_mask;
  logic [7:0]  stall_mask;
  logic [31:0] err_mask;

  initial begin
    i_reset       = 1'b1;
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = '0;
    bus.i_wb_data = '0;
    bus.i_wb_sel  = '1;
    bus.i_s_stall = '0;
    bus.i_s_ack   = '0;
    bus.i_s_err   = '0;
    bus.i_s_data  = '0;

    // Reset state
    tick();
    tick();
    check("rst_ack",   32'(bus.o_wb_ack),   32'd0);
    check("rst_err",   32'(bus.o_wb_err),   32'd0);
    check("rst_data",  bus.o_wb_data,       32'd0);
    check("rst_s_cyc", 32'(bus.o_s_cyc),    32'd0);
    check("rst_s_stb", 32'(bus.o_s_stb),    32'd0);
    #3 i_reset = 1'b0;
    tick();

    // Read from slave 2, slave acks 3 cycles after the strobe
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'h2000_0010;
    #1;
    check("rd_s_cyc",  32'(bus.o_s_cyc),  32'b100);
    check("rd_s_stb",  32'(bus.o_s_stb),  32'b100);
    check("rd_stall",  32'(bus.o_wb_stall), 32'd0);
    check("rd_s_addr", 32'(bus.o_s_addr), 32'h2000_0010);
    tick();
    bus.i_wb_stb = 1'b0;
    check("rd_busy_cyc", 32'(bus.o_s_cyc), 32'b100);
    tick();
    tick();
    bus.i_s_ack = 3'b100;
    set_sdata(2, 32'hDEAD_BEEF);
    #1;
    check("rd_ack_early", 32'(bus.o_wb_ack), 32'd0);
    tick();
    bus.i_s_ack = '0;
    check("rd_ack",  32'(bus.o_wb_ack), 32'd1);
    check("rd_data", bus.o_wb_data,     32'hDEAD_BEEF);
    tick();
    check("rd_ack_once", 32'(bus.o_wb_ack), 32'd0);
    check("rd_data_hold", bus.o_wb_data,    32'hDEAD_BEEF);

    // Pipelined burst of 6 writes to slave 1, acks lag accepts by 5 cycles
    bus.i_wb_we = 1'b1;
    sent       = 0;
    ack_mask   = '0;
    stall_mask = '0;
    for (int c = 0; c < 16; c++) begin
      bus.i_wb_stb  = (sent < 6);
      bus.i_wb_addr = 30'h1000_0000 + 30'(sent);
      bus.i_wb_data = 32'hA0 + 32'(sent);
      ack_v = 1'b0;
      for (int j = 0; j < sent; j++)
        if (acc_cyc[j] + 5 == c) ack_v = 1'b1;
      bus.i_s_ack = {1'b0, ack_v, 1'b0};
      #1;
      if (c < 8) stall_mask[c] = bus.o_wb_stall;
      ack_mask[c] = bus.o_wb_ack;
      if (bus.i_wb_stb && !bus.o_wb_stall) begin
        acc_cyc[sent] = c;
        sent++;
      end
      tick();
    end
    bus.i_wb_stb = 1'b0;
    bus.i_s_ack  = '0;
    #1;
    check("wr_accepts",    32'(sent),       32'd6);
    check("wr_stall_mask", 32'(stall_mask), 32'h30);
    check("wr_ack_mask",   32'(ack_mask),   32'h33C0);
    check("wr_idle_cyc",   32'(bus.o_s_cyc), 32'd0);
    bus.i_wb_we = 1'b0;
    tick();

    // Unmapped index 3, then a normal access to slave 0
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'h3000_0000;
    #1;
    check("bad_s_stb", 32'(bus.o_s_stb),    32'd0);
    check("bad_stall", 32'(bus.o_wb_stall), 32'd0);
    tick();
    bus.i_wb_stb = 1'b0;
    #1;
    check("bad_err",   32'(bus.o_wb_err),   32'd1);
    check("bad_stall_after", 32'(bus.o_wb_stall), 32'd1);
    tick();
    check("bad_err_once", 32'(bus.o_wb_err), 32'd0);
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'h0000_0004;
    #1;
    check("s0_s_stb", 32'(bus.o_s_stb), 32'b001);
    tick();
    bus.i_wb_stb = 1'b0;
    bus.i_s_ack  = 3'b001;
    set_sdata(0, 32'h1234_5678);
    tick();
    bus.i_s_ack = '0;
    check("s0_ack",  32'(bus.o_wb_ack), 32'd1);
    check("s0_data", bus.o_wb_data,     32'h1234_5678);
    check("s0_err",  32'(bus.o_wb_err), 32'd0);
    tick();

    // Slave 0 never acks: watchdog fires 16 cycles after the accept
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'h0000_0008;
    tick();
    bus.i_wb_stb = 1'b0;
    err_mask = '0;
    for (int k = 1; k <= 22; k++) begin
      bus.i_s_ack = (k == 20) ? 3'b001 : 3'b000;
      tick();
      err_mask[k] = bus.o_wb_err;
      if (k == 15) check("to_cyc_before", 32'(bus.o_s_cyc), 32'b001);
      if (k == 16) check("to_cyc_after",  32'(bus.o_s_cyc), 32'd0);
      if (k == 20 || k == 21) check("to_late_ack", 32'(bus.o_wb_ack), 32'd0);
    end
    bus.i_s_ack = '0;
    check("to_err_mask", err_mask, 32'h0001_0000);
    bus.i_wb_cyc = 1'b0;
    tick();
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'h2000_0000;
    #1;
    check("to_idle_stb", 32'(bus.o_s_stb), 32'b100);
    tick();
    bus.i_wb_stb = 1'b0;
    bus.i_s_ack  = 3'b100;
    tick();
    bus.i_s_ack = '0;
    check("to_recover_ack", 32'(bus.o_wb_ack), 32'd1);
    tick();

    // Master drops cyc with a request outstanding: the slave's reply is discarded
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'h2000_0004;
    tick();
    bus.i_wb_stb = 1'b0;
    bus.i_wb_cyc = 1'b0;
    bus.i_s_ack  = 3'b100;
    #1;
    check("drop_s_cyc", 32'(bus.o_s_cyc), 32'd0);
    tick();
    bus.i_s_ack  = '0;
    bus.i_wb_cyc = 1'b1;
    #1;
    check("drop_no_ack", 32'(bus.o_wb_ack), 32'd0);
    check("drop_idle",   32'(bus.o_s_cyc),  32'd0);
    tick();

    // Strobe to slave 0 then slave 1: the second waits for slave 0 to drain
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'h0000_0000;
    tick();
    bus.i_wb_addr = 30'h1000_0000;
    #1;
    check("b2b_stall",  32'(bus.o_wb_stall), 32'd1);
    check("b2b_no_stb", 32'(bus.o_s_stb),    32'd0);
    tick();
    bus.i_s_ack = 3'b001;
    #1;
    check("b2b_stall_ack", 32'(bus.o_wb_stall), 32'd1);
    tick();
    bus.i_s_ack = '0;
    #1;
    check("b2b_go",      32'(bus.o_wb_stall), 32'd0);
    check("b2b_s1_stb",  32'(bus.o_s_stb),    32'b010);
    check("b2b_s0_ack",  32'(bus.o_wb_ack),   32'd1);
    tick();
    bus.i_wb_addr = 30'h1000_0001;
    bus.i_s_ack   = 3'b010;
    set_sdata(1, 32'hCAFE_F00D);
    tick();
    bus.i_wb_stb = 1'b0;
    bus.i_s_ack  = '0;
    #1;
    check("b2b_s1_ack",  32'(bus.o_wb_ack), 32'd1);
    check("b2b_s1_data", bus.o_wb_data,     32'hCAFE_F00D);
    check("b2b_s1_cyc",  32'(bus.o_s_cyc),  32'b010);

    // Asynchronous reset in the middle of BUSY
    #2 i_reset = 1'b1;
    #1;
    check("arst_ack",  32'(bus.o_wb_ack), 32'd0);
    check("arst_data", bus.o_wb_data,     32'd0);
    check("arst_cyc",  32'(bus.o_s_cyc),  32'd0);
    #2 i_reset = 1'b0;
    tick();
    check("arst_idle", 32'(bus.o_s_cyc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_interconnect_n.md
Name: wb_interconnect_n

Overview:
- Parametrised single-master, N-slave Wishbone (pipelined, B4 with stall) address decoder and response router.
- Sits between WB_master and multiple WB slaves in the UART-bridge system.
- Adds slave selection by upper address bits and tracking of outstanding requests.
- Adds error generation for unmapped addresses and a watchdog bus timeout that aborts a hung cycle.

Parameters:
- AW, 30, address width (word address).
- DW, 32, data width; must be a multiple of 8.
- N_SLAVES, 4, number of slave ports; 1..2**SEL_W.
- SEL_W, 2, number of top address bits used as the slave index.
- MAX_OUT, 4, maximum outstanding requests in one cycle.
- TIMEOUT, 1024, cycles without progress before a bus error; must be >= 2.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc  in  1  master cycle
- i_wb_stb  in  1  master strobe
- i_wb_we  in  1  write enable
- i_wb_addr  in  AW  address
- i_wb_data  in  DW  write data
- i_wb_sel  in  DW/8  byte select
- o_wb_stall  out  1  stall to master
- o_wb_ack  out  1  ack to master (registered)
- o_wb_err  out  1  error to master (registered)
- o_wb_data  out  DW  read data to master (registered)
- o_s_cyc  out  N_SLAVES  per-slave cycle
- o_s_stb  out  N_SLAVES  per-slave strobe
- o_s_we  out  1  broadcast we
- o_s_addr  out  AW  broadcast address
- o_s_data  out  DW  broadcast write data
- o_s_sel  out  DW/8  broadcast byte select
- i_s_stall  in  N_SLAVES  per-slave stall
- i_s_ack  in  N_SLAVES  per-slave ack
- i_s_err  in  N_SLAVES  per-slave err
- i_s_data  in  N_SLAVES*DW  per-slave read data; slave k occupies bits [k*DW +: DW]

Behaviour:
- Reset (async, active-high):
  - state=IDLE, outstanding=0, lock=0, watchdog=0.
  - o_wb_ack=0, o_wb_err=0, o_wb_data=0.
  - o_s_cyc=0, o_s_stb=0.
- Slave index and broadcast signals:
  - idx = i_wb_addr[AW-1 -: SEL_W].
  - Address is mapped iff idx < N_SLAVES.
  - o_s_we/addr/data/sel follow the master inputs combinationally.
- States: IDLE, BUSY, BADADDR, ABORT.
- IDLE:
  - stb & cyc & mapped: lock<=idx, forward the strobe to slave idx, go to BUSY.
  - stb & cyc & unmapped: o_wb_stall=0, request accepted, go to BADADDR.
- BUSY:
  - o_s_cyc[lock] = i_wb_cyc.
  - o_s_stb[lock] = i_wb_stb when idx==lock.
  - o_wb_stall = i_s_stall[lock] when idx==lock and outstanding<MAX_OUT.
  - Request to a different idx, or outstanding==MAX_OUT: o_wb_stall=1, no slave stb; held until drained.
  - Accept (stb & !stall) increments outstanding; i_s_ack[lock] or i_s_err[lock] decrements it. Simultaneous accept and response: count unchanged.
  - Count reaches 0 with no new accept: go to IDLE.
- Response path, 1 cycle latency:
  - o_wb_ack <= i_s_ack[lock]; o_wb_err <= i_s_err[lock].
  - o_wb_data <= i_s_data[lock] on ack; held otherwise.
  - Responses from non-locked slaves are ignored.
- BADADDR: o_wb_err=1 for exactly one cycle (the cycle after accept), stall=1, then IDLE.
- Watchdog:
  - Counts while outstanding>0; cleared on any accept or locked response.
  - On reaching TIMEOUT-1: o_wb_err<=1 for one cycle, outstanding<=0, o_s_cyc<=0, go to ABORT.
- ABORT:
  - stall=1, all slave cyc/stb=0, late slave acks dropped.
  - Go to IDLE when i_wb_cyc=0.
- Master drops i_wb_cyc in any state:
  - o_s_cyc=0 the same cycle.
  - Next edge: outstanding=0, watchdog=0, state=IDLE.
  - Pending acks are discarded; no o_wb_ack/err is produced for them.
- Every slave and master output is 0 whenever i_wb_cyc=0, except o_wb_data, which holds.

Test Plan:
- Read slave 2 addr 0x2000_0010 (SEL_W=2, AW=30): slave acks 3 cycles after stb with data 0xDEADBEEF -> o_wb_ack 1 cycle after slave ack, o_wb_data=0xDEADBEEF, o_s_cyc=0b0100.
- Pipelined burst of 6 writes to slave 1, MAX_OUT=4, slave acks lag by 5 -> o_wb_stall asserted after 4th accept, 6 acks total, outstanding returns to 0, state IDLE.
- N_SLAVES=3, access to idx 3 -> no o_s_stb, o_wb_err=1 for exactly one cycle, following access to slave 0 completes normally.
- Slave 0 never acks, TIMEOUT=16 -> o_wb_err pulses exactly 16 cycles after the accept, o_s_cyc drops, late ack at cycle 20 produces no o_wb_ack; IDLE after i_wb_cyc low.
- Back-to-back strobes to slave 0 then slave 1 in one cycle -> second stalls until slave 0's ack, then routes to slave 1; i_reset pulsed mid-BUSY clears all outputs asynchronously.
